// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one SDRAM controller command port between three requesters:
// video DMA (port 0), CPU (port 1) and an auxiliary/SPI boot port (port 2).
// One transaction runs at a time through the states IDLE -> ISSUE -> WAIT ->
// RELEASE. The winner's command fields are captured in IDLE, so the command
// toward the controller stays stable for the whole transaction.
//
// Optional feature (macro SDRAM_ARB_STARVE_EN):
//   When defined, the CPU and aux ports each get a 4-bit starvation counter.
//   A port that has been bypassed STARVE_LIMIT times in a row wins the next
//   arbitration. CPU beats aux if both are promoted. When the macro is not
//   defined, arbitration is strictly video > CPU > aux.
//
// Ports:
//   clk, reset_in                 clock, synchronous active-low reset
//   vid_* / cpu_* / aux_*         requester ports (req, we, addr, wdata, bytesel)
//   vid_ack / cpu_ack / aux_ack   one-cycle completion pulses
//   rdata                         read data registered on the controller ack
//   sdr_*                         command port toward the SDRAM controller
//   sdr_ack, sdr_rdata            completion and read data from the controller
//   grant_id                      owning port (0 vid, 1 cpu, 2 aux, 3 none)
//   busy                          high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  vid_req,
    input  logic                  vid_we,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    input  logic [15:0]           vid_wdata,
    input  logic [1:0]            vid_bytesel,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    input  logic [1:0]            cpu_bytesel,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [15:0]           aux_wdata,
    input  logic [1:0]            aux_bytesel,
    output logic                  vid_ack,
    output logic                  cpu_ack,
    output logic                  aux_ack,
    output logic [15:0]           rdata,
    output logic                  sdr_req,
    output logic                  sdr_we,
    output logic [ADDR_WIDTH-1:0] sdr_addr,
    output logic [15:0]           sdr_wdata,
    output logic [1:0]            sdr_bytesel,
    input  logic                  sdr_ack,
    input  logic [15:0]           sdr_rdata,
    output logic [1:0]            grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // An out-of-range starvation limit would make the 4-bit counters unable
    // to ever reach it, so refuse to elaborate with one.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limitCheck
        $error("sdram_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t                  r_state;
    state_t                  w_nextState;
    logic [1:0]              r_grant;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_wdata;
    logic [1:0]              r_bytesel;
    logic [15:0]             r_rdata;

    logic                    w_anyReq;
    logic [1:0]              w_winner;
    logic                    w_winWe;
    logic [ADDR_WIDTH-1:0]   w_winAddr;
    logic [15:0]             w_winWdata;
    logic [1:0]              w_winBytesel;

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_cpuStarve;
    logic [3:0] r_auxStarve;
`endif

    // Pick the winner among the current requests. Fixed priority is the
    // baseline; a promoted (starved) port overrides it, and the req term
    // keeps a stale counter from granting a port that has since gone away.
    always_comb begin
        w_anyReq = vid_req | cpu_req | aux_req;
        w_winner = 2'd3;
        if (vid_req) begin
            w_winner = 2'd0;
        end else if (cpu_req) begin
            w_winner = 2'd1;
        end else if (aux_req) begin
            w_winner = 2'd2;
        end
`ifdef SDRAM_ARB_STARVE_EN
        if (cpu_req && r_cpuStarve == LP_LIMIT) begin
            w_winner = 2'd1;
        end else if (aux_req && r_auxStarve == LP_LIMIT) begin
            w_winner = 2'd2;
        end
`endif
    end

    // Route the winning port's command fields toward the capture registers.
    always_comb begin
        w_winWe      = vid_we;
        w_winAddr    = vid_addr;
        w_winWdata   = vid_wdata;
        w_winBytesel = vid_bytesel;
        case (w_winner)
            2'd1: begin
                w_winWe      = cpu_we;
                w_winAddr    = cpu_addr;
                w_winWdata   = cpu_wdata;
                w_winBytesel = cpu_bytesel;
            end
            2'd2: begin
                w_winWe      = aux_we;
                w_winAddr    = aux_addr;
                w_winWdata   = aux_wdata;
                w_winBytesel = aux_bytesel;
            end
            default: begin
            end
        endcase
    end

    // Next-state logic. A controller ack already in ISSUE skips WAIT; acks
    // seen in IDLE or RELEASE are not looked at and therefore ignored.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ISSUE;
            ISSUE:   w_nextState = sdr_ack ? RELEASE : WAIT;
            WAIT:    if (sdr_ack) w_nextState = RELEASE;
            RELEASE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register plus the captured command and read data. The command
    // is captured only on the IDLE -> ISSUE edge, so it cannot move while
    // sdr_req is high even if the requester changes or drops its inputs.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_state   <= IDLE;
            r_grant   <= 2'd3;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bytesel <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_anyReq) begin
                r_grant   <= w_winner;
                r_we      <= w_winWe;
                r_addr    <= w_winAddr;
                r_wdata   <= w_winWdata;
                r_bytesel <= w_winBytesel;
            end
            if ((r_state == ISSUE || r_state == WAIT) && sdr_ack) begin
                r_rdata <= sdr_rdata;
            end
        end
    end

`ifdef SDRAM_ARB_STARVE_EN
    // Starvation counters only move on arbitration cycles (IDLE). A port is
    // bypassed when it requests and someone else wins. Counting saturates at
    // the limit so an aux port that loses to a promoted CPU stays promoted.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_cpuStarve <= '0;
            r_auxStarve <= '0;
        end else if (r_state == IDLE) begin
            if (!cpu_req || w_winner == 2'd1) begin
                r_cpuStarve <= '0;
            end else if (r_cpuStarve != LP_LIMIT) begin
                r_cpuStarve <= r_cpuStarve + 4'd1;
            end
            if (!aux_req || w_winner == 2'd2) begin
                r_auxStarve <= '0;
            end else if (r_auxStarve != LP_LIMIT) begin
                r_auxStarve <= r_auxStarve + 4'd1;
            end
        end
    end
`endif

    assign sdr_req     = (r_state == ISSUE) || (r_state == WAIT);
    assign sdr_we      = r_we;
    assign sdr_addr    = r_addr;
    assign sdr_wdata   = r_wdata;
    assign sdr_bytesel = r_bytesel;
    assign rdata       = r_rdata;
    assign busy        = (r_state != IDLE);
    assign grant_id    = (r_state == IDLE) ? 2'd3 : r_grant;
    assign vid_ack     = (r_state == RELEASE) && (r_grant == 2'd0);
    assign cpu_ack     = (r_state == RELEASE) && (r_grant == 2'd1);
    assign aux_ack     = (r_state == RELEASE) && (r_grant == 2'd2);

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: width of all address fields.
REQ-002 Parameter STARVE_LIMIT, default 4, legal range 1-15: number of consecutive bypasses after which a waiting low-priority port is promoted.
REQ-003 clk  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset_in  in  1  synchronous, active-low reset.
REQ-005 vid_req, vid_we, vid_addr, vid_wdata, vid_bytesel  in  1/1/ADDR_WIDTH/16/2  video DMA port (port 0), held stable from request until acknowledge.
REQ-006 cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_bytesel  in  1/1/ADDR_WIDTH/16/2  CPU port (port 1), held stable from request until acknowledge.
REQ-007 aux_req, aux_we, aux_addr, aux_wdata, aux_bytesel  in  1/1/ADDR_WIDTH/16/2  auxiliary/SPI boot port (port 2), held stable from request until acknowledge.
REQ-008 vid_ack, cpu_ack, aux_ack  out  1 each  one-cycle completion pulse for the corresponding port.
REQ-009 rdata  out  16  registered read data, valid in the cycle an ack is pulsed.
REQ-010 sdr_req, sdr_we, sdr_addr, sdr_wdata, sdr_bytesel  out  1/1/ADDR_WIDTH/16/2  single command port toward the SDRAM controller.
REQ-011 sdr_ack  in  1  one-cycle completion pulse from the SDRAM controller.
REQ-012 sdr_rdata  in  16  controller read data, valid when sdr_ack is high.
REQ-013 grant_id  out  2  currently owning port: 0 video, 1 CPU, 2 aux, 3 none.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RELEASE.
REQ-016 IDLE: if any req is high, the FSM SHALL latch the winner's we/addr/wdata/bytesel and go to ISSUE on the next edge; otherwise it SHALL remain in IDLE.
REQ-017 Default priority SHALL be fixed: video > CPU > aux.
REQ-018 ISSUE: sdr_req SHALL be 1 with the latched fields; the FSM SHALL go to WAIT on the next edge.
REQ-019 WAIT: sdr_req SHALL stay 1 until sdr_ack; on sdr_ack the FSM SHALL register sdr_rdata into rdata and go to RELEASE.
REQ-020 sdr_ack arriving in ISSUE SHALL be treated exactly as in WAIT (go directly to RELEASE).
REQ-021 RELEASE: sdr_req SHALL be 0, the granted port's ack SHALL be 1 for exactly this cycle, and the FSM SHALL return to IDLE.
REQ-022 Latency: a request sampled in IDLE at cycle T SHALL produce sdr_req at T+1; an sdr_ack at cycle A SHALL produce the port ack at A+1; the earliest next arbitration SHALL occur at A+2.
REQ-023 A req that is still high in IDLE after its own ack SHALL be treated as a new request.
REQ-024 sdr_ack received in IDLE or RELEASE SHALL be ignored and SHALL NOT produce any port ack.
REQ-025 The sdr_* command fields SHALL be driven only from the latched registers and SHALL NOT change while sdr_req is high.
REQ-026 A requester dropping req mid-transaction SHALL NOT abort it; the ack SHALL still be pulsed.
REQ-027 grant_id SHALL be 3 in IDLE and SHALL hold the winner's ID in ISSUE, WAIT, and RELEASE.

Reset
REQ-028 While reset_in is 0 at a clock edge, the FSM SHALL go to IDLE and the following SHALL be set: sdr_req=0, sdr_we=0, sdr_addr=0, sdr_wdata=0, sdr_bytesel=0, all acks=0, rdata=0, grant_id=3, busy=0, and starvation counters=0.
REQ-029 Reset mid-transaction SHALL discard the transaction without emitting any ack; the SDRAM controller is reset by the same signal.

Configuration
REQ-030 Macro SDRAM_ARB_STARVE_EN defined: each of CPU and aux SHALL have a 4-bit counter that increments when the port's req is high in IDLE and another port wins. The counter SHALL clear when the port is granted or its req is low in IDLE.
REQ-031 With SDRAM_ARB_STARVE_EN defined, a port whose counter equals STARVE_LIMIT SHALL win the next arbitration over all others; if both CPU and aux are promoted, CPU SHALL win.
REQ-032 Macro SDRAM_ARB_STARVE_EN undefined: no counters SHALL be built, and arbitration SHALL be strictly fixed-priority per REQ-017.

Verification
REQ-033 vid_req, cpu_req, and aux_req all rise together, with the controller acking 3 cycles after each sdr_req -> grant order SHALL be 0, 1, 2, with sdr_req at T+1 and vid_ack 4 cycles after the first sdr_req rises.
REQ-034 CPU read at addr 0x000123, with the controller returning 0xBEEF -> cpu_ack SHALL be one cycle wide, rdata=0xBEEF in that cycle, and sdr_addr=0x000123 throughout.
REQ-035 Video requests continuously while cpu_req is held, with SDRAM_ARB_STARVE_EN defined and STARVE_LIMIT=4 -> the CPU SHALL be granted after exactly 4 video grants; with the macro undefined, the CPU SHALL never be granted.
REQ-036 reset_in driven low during WAIT of an aux write -> the next cycle SHALL show sdr_req=0 and grant_id=3, and aux_ack SHALL never pulse.
REQ-037 Spurious sdr_ack injected in IDLE -> no ack SHALL pulse, and rdata SHALL be unchanged.
REQ-038 sdr_ack in the same cycle as ISSUE -> the port ack SHALL pulse in the next cycle, and the FSM SHALL pass through RELEASE back to IDLE.
